// File: rtl/psk_symbol_mapper.sv
// Maps AXIS bit beats to signed BPSK/QPSK I/Q points at the symbol tick, tracking packet framing.
// Optional feature: define DIFF_ENC_EN for differential (phase-accumulating) encoding.
module psk_symbol_mapper #(
  parameter int BYTES    = 1,
  parameter int AMP_W    = 16,
  parameter int BPSK_AMP = 32767,
  parameter int QPSK_AMP = 23170
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic [BYTES*8-1:0]      I_tdata,
  input  logic                    I_tvalid,
  output logic                    I_tready,
  input  logic                    I_tlast,
  input  logic                    I_tuser,
  output logic signed [AMP_W-1:0] O_i,
  output logic signed [AMP_W-1:0] O_q,
  output logic                    O_tvalid,
  input  logic                    O_tready,
  output logic                    O_tlast,
  output logic                    O_tuser,
  output logic                    in_pkt,
  output logic                    underrun,
  output logic [15:0]             sym_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic signed [AMP_W-1:0] BPSK_P = AMP_W'(BPSK_AMP);
  localparam logic signed [AMP_W-1:0] BPSK_N = -BPSK_P;
  localparam logic signed [AMP_W-1:0] QPSK_P = AMP_W'(QPSK_AMP);
  localparam logic signed [AMP_W-1:0] QPSK_N = -QPSK_P;

  state_t                  state_r, state_nxt_s;
  logic                    ready_s, accept_s, gap_s, first_s;
  logic signed [AMP_W-1:0] map_i_s, map_q_s;
  logic                    unused_s;

  assign unused_s = ^I_tdata[BYTES*8-1:2];
  assign ready_s  = !O_tvalid | O_tready;
  assign I_tready = ready_s;
  assign accept_s = clk_enable & I_tvalid & ready_s;
  assign gap_s    = clk_enable & !I_tvalid & ready_s;
  assign first_s  = (state_r == IDLE);

`ifdef DIFF_ENC_EN
  logic [1:0] phase_r, phase_inc_s, phase_new_s;

  // Phase increment (Gray for QPSK, 0/2 for BPSK) and constellation from the new phase
  always_comb begin
    phase_inc_s = 2'd0;
    map_i_s     = '0;
    map_q_s     = '0;
    if (I_tuser) begin
      phase_inc_s = {I_tdata[0], 1'b0};
    end else begin
      case (I_tdata[1:0])
        2'b00:   phase_inc_s = 2'd0;
        2'b01:   phase_inc_s = 2'd1;
        2'b11:   phase_inc_s = 2'd2;
        2'b10:   phase_inc_s = 2'd3;
        default: phase_inc_s = 2'd0;
      endcase
    end
    phase_new_s = (first_s ? 2'd0 : phase_r) + phase_inc_s;
    if (I_tuser) begin
      map_i_s = phase_new_s[1] ? BPSK_N : BPSK_P;
      map_q_s = '0;
    end else begin
      case (phase_new_s)
        2'd0:    begin map_i_s = QPSK_P; map_q_s = QPSK_P; end
        2'd1:    begin map_i_s = QPSK_N; map_q_s = QPSK_P; end
        2'd2:    begin map_i_s = QPSK_N; map_q_s = QPSK_N; end
        2'd3:    begin map_i_s = QPSK_P; map_q_s = QPSK_N; end
        default: begin map_i_s = '0;     map_q_s = '0;     end
      endcase
    end
  end

  // Phase only moves on accepted beats; it restarts at each packet's first beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 2'd0;
    end else if (accept_s) begin
      phase_r <= phase_new_s;
    end
  end
`else
  // Direct constellation map
  always_comb begin
    map_i_s = '0;
    map_q_s = '0;
    if (I_tuser) begin
      map_i_s = I_tdata[0] ? BPSK_N : BPSK_P;
      map_q_s = '0;
    end else begin
      map_i_s = I_tdata[0] ? QPSK_N : QPSK_P;
      map_q_s = I_tdata[1] ? QPSK_N : QPSK_P;
    end
  end
`endif

  // Packet FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !I_tlast) state_nxt_s = ACTIVE;
        else                      state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (accept_s && I_tlast) state_nxt_s = IDLE;
        else                     state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Packet state, framing status and symbol counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      in_pkt   <= 1'b0;
      underrun <= 1'b0;
      sym_cnt  <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      in_pkt  <= (state_nxt_s == ACTIVE);
      if (gap_s && (state_r == ACTIVE)) underrun <= 1'b1;
      if (accept_s) sym_cnt <= first_s ? 16'd1 : sym_cnt + 16'd1;
    end
  end

  // Single output register; idle gaps drive zero energy, stalls hold everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_i      <= '0;
      O_q      <= '0;
      O_tvalid <= 1'b0;
      O_tlast  <= 1'b0;
      O_tuser  <= 1'b1;
    end else if (clk_enable && ready_s) begin
      if (I_tvalid) begin
        O_i      <= map_i_s;
        O_q      <= map_q_s;
        O_tvalid <= 1'b1;
        O_tlast  <= I_tlast;
        O_tuser  <= I_tuser;
      end else begin
        O_i      <= '0;
        O_q      <= '0;
        O_tvalid <= 1'b0;
        O_tlast  <= 1'b0;
      end
    end
  end

endmodule
